// File: rtl/board_motion_controller_pkg.sv
// Constants and state encoding shared by the board controller and pixel_generation.
// The clamp helper keeps the board inside the visible area without wrapping.
package board_motion_controller_pkg;

    localparam int X_MAX        = 639;
    localparam int Y_MAX        = 479;
    localparam int BOARD_WIDTH  = 64;
    localparam int BOARD_HEIGHT = 16;

    localparam logic [9:0] REFRESH_LINE = 10'd481;
    localparam logic [9:0] X_INIT       = 10'd288;
    localparam logic [9:0] BOARD_Y_POS  = 10'd464;

    localparam logic [3:0] SLOW_STEP    = 4'd2;
    localparam logic [3:0] FAST_STEP    = 4'd6;
    localparam logic [3:0] ACCEL_FRAMES = 4'd8;

    // Rightmost legal left edge: the whole board stays on screen.
    localparam logic signed [10:0] X_LIMIT = 11'(X_MAX + 1 - BOARD_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SLOW = 2'd1,
        ST_FAST = 2'd2
    } state_e;

    function automatic logic [9:0] clamp_x(input logic signed [10:0] pos);
        logic [9:0] res;
        if (pos < 11'sd0) begin
            res = 10'd0;
        end else if (pos > X_LIMIT) begin
            res = X_LIMIT[9:0];
        end else begin
            res = pos[9:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/board_motion_controller_if.sv
// Button, pixel-counter and board-position signals between the board, VGA timing and pixel generator.
interface board_motion_controller_if;

    logic       btn_l;
    logic       btn_r;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] board_x;
    logic [9:0] board_y;
    logic       moving;

    modport master (
        output btn_l, btn_r, x, y,
        input  board_x, board_y, moving
    );

    modport slave (
        input  btn_l, btn_r, x, y,
        output board_x, board_y, moving
    );

endinterface

// File: rtl/board_motion_controller_frame_tick_gen.sv
// One-cycle pulse at the start of vertical refresh; the pixel counters dwell on
// the refresh position for several clocks, so only the rising edge is reported.
module board_motion_controller_frame_tick_gen
    import board_motion_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] x_i,
    input  logic [9:0] y_i,
    output logic       tick_o
);

    logic raw;
    logic raw_q;

    assign raw = (y_i == REFRESH_LINE) && (x_i == 10'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            raw_q <= 1'b0;
        end else begin
            raw_q <= raw;
        end
    end

    assign tick_o = raw & ~raw_q;

endmodule

// File: rtl/board_motion_controller.sv
// Steps the paddle left/right once per video frame with slow/fast acceleration.
//   state | meaning
//   IDLE  | no direction held at the last tick, board still
//   SLOW  | moving SLOW_STEP per frame, counting same-direction frames
//   FAST  | held long enough, moving FAST_STEP per frame
module board_motion_controller
    import board_motion_controller_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    board_motion_controller_if.slave   bus
);

    logic [1:0]        sync_l_q;
    logic [1:0]        sync_r_q;
    logic              btn_l_s;
    logic              btn_r_s;
    logic              tick;

    state_e            state_q, state_d;
    logic [3:0]        hold_q, hold_d;
    logic [3:0]        hold_inc;
    logic signed [1:0] last_dir_q, last_dir_d;
    logic signed [1:0] dir;
    logic [9:0]        board_x_q, board_x_d;
    logic [9:0]        board_y_q;
    logic              moving_q;

    logic [3:0]        step;
    logic signed [10:0] pos_cur;
    logic signed [10:0] pos_step;
    logic signed [10:0] pos_sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_l_q <= 2'b00;
            sync_r_q <= 2'b00;
        end else begin
            sync_l_q <= {sync_l_q[0], bus.btn_l};
            sync_r_q <= {sync_r_q[0], bus.btn_r};
        end
    end

    assign btn_l_s = sync_l_q[1];
    assign btn_r_s = sync_r_q[1];

    board_motion_controller_frame_tick_gen u_tick (
        .clk    (clk),
        .reset  (reset),
        .x_i    (bus.x),
        .y_i    (bus.y),
        .tick_o (tick)
    );

    always_comb begin
        dir = 2'sd0;
        if (btn_r_s && !btn_l_s) begin
            dir = 2'sd1;
        end else if (btn_l_s && !btn_r_s) begin
            dir = -2'sd1;
        end
    end

    assign hold_inc = (hold_q == 4'hF) ? hold_q : hold_q + 4'd1;

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        last_dir_d = last_dir_q;
        step       = 4'd0;
        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (dir != 2'sd0) begin
                        state_d    = ST_SLOW;
                        step       = SLOW_STEP;
                        hold_d     = 4'd1;
                        last_dir_d = dir;
                    end
                end
                ST_SLOW: begin
                    if (dir == 2'sd0) begin
                        state_d = ST_IDLE;
                        hold_d  = 4'd0;
                    end else if (dir != last_dir_q) begin
                        step       = SLOW_STEP;
                        hold_d     = 4'd1;
                        last_dir_d = dir;
                    end else begin
                        step   = SLOW_STEP;
                        hold_d = hold_inc;
                        if (hold_inc >= ACCEL_FRAMES) begin
                            state_d = ST_FAST;
                        end
                    end
                end
                ST_FAST: begin
                    if (dir == 2'sd0) begin
                        state_d = ST_IDLE;
                        hold_d  = 4'd0;
                    end else if (dir != last_dir_q) begin
                        state_d    = ST_SLOW;
                        step       = SLOW_STEP;
                        hold_d     = 4'd1;
                        last_dir_d = dir;
                    end else begin
                        step = FAST_STEP;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    hold_d  = 4'd0;
                end
            endcase
        end
    end

    // Signed arithmetic so a left step from near zero clamps instead of wrapping.
    always_comb begin
        pos_cur  = $signed({1'b0, board_x_q});
        pos_step = $signed({7'd0, step});
        if (dir[1]) begin
            pos_sum = pos_cur - pos_step;
        end else begin
            pos_sum = pos_cur + pos_step;
        end
        board_x_d = clamp_x(pos_sum);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            hold_q     <= 4'd0;
            last_dir_q <= 2'sd0;
            board_x_q  <= X_INIT;
            board_y_q  <= BOARD_Y_POS;
            moving_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            last_dir_q <= last_dir_d;
            board_x_q  <= board_x_d;
            board_y_q  <= BOARD_Y_POS;
            moving_q   <= (state_d != ST_IDLE);
        end
    end

    assign bus.board_x = board_x_q;
    assign bus.board_y = board_y_q;
    assign bus.moving  = moving_q;

endmodule

// File: tb/tb_board_motion_controller.sv
// Self-checking bench for board_motion_controller: table of per-frame vectors plus
// hand-written sequences for raw-dwell, between-tick presses, async reset and wall clamping.
module tb_board_motion_controller;

    logic clk = 1'b0;
    logic reset;

    board_motion_controller_if bus();

    board_motion_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       l;
        logic       r;
        int         raw;
        logic [9:0] bx;
        logic       mv;
    } vec_t;

    typedef struct {
        logic [9:0] bx;
        logic       mv;
        string      name;
    } exp_t;

    vec_t vecs[28];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [10:0] act, input logic [10:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d", nm, act, req);
        end
    endtask

    task automatic set_vec(input int i, input logic l, input logic r, input int raw,
                           input int bx, input logic mv);
        vecs[i] = '{l, r, raw, 10'(bx), mv};
    endtask

    // One video frame: buttons settle through the synchronizer, then the refresh
    // position is presented for raw cycles; results are compared after the tick.
    task automatic do_frame(input logic l, input logic r, input int raw,
                            input int bx, input logic mv, input string nm);
        exp_t e;
        sb.push_back('{10'(bx), mv, nm});
        @(negedge clk);
        bus.btn_l = l;
        bus.btn_r = r;
        repeat (3) @(negedge clk);
        bus.y = 10'd481;
        bus.x = 10'd0;
        repeat (raw) @(negedge clk);
        bus.x = 10'd1;
        repeat (2) @(negedge clk);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 11'd1, 11'd0);
        end else begin
            e = sb.pop_front();
            chk({e.name, "_board_x"}, {1'b0, bus.board_x}, {1'b0, e.bx});
            chk({e.name, "_moving"}, {10'd0, bus.moving}, {10'd0, e.mv});
            chk({e.name, "_board_y"}, {1'b0, bus.board_y}, 11'd464);
        end
    endtask

    initial begin
        reset     = 1'b1;
        bus.btn_l = 1'b0;
        bus.btn_r = 1'b0;
        bus.x     = 10'd1;
        bus.y     = 10'd0;

        for (int i = 0; i < 3; i++) set_vec(i, 0, 0, 2, 288, 0);
        set_vec(3, 0, 1, 2, 290, 1);
        set_vec(4, 0, 0, 2, 290, 0);
        for (int i = 0; i < 8; i++) set_vec(5 + i, 0, 1, 2, 292 + 2 * i, 1);
        set_vec(13, 0, 1, 2, 312, 1);
        set_vec(14, 0, 1, 2, 318, 1);
        set_vec(15, 1, 1, 2, 318, 0);
        set_vec(16, 0, 1, 4, 320, 1);
        set_vec(17, 1, 0, 2, 318, 1);
        for (int i = 0; i < 7; i++) set_vec(18 + i, 1, 0, 2, 316 - 2 * i, 1);
        set_vec(25, 1, 0, 2, 298, 1);
        set_vec(26, 0, 1, 2, 300, 1);
        set_vec(27, 0, 0, 2, 300, 0);

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_board_x", {1'b0, bus.board_x}, 11'd288);
        chk("reset_board_y", {1'b0, bus.board_y}, 11'd464);
        chk("reset_moving", {10'd0, bus.moving}, 11'd0);

        for (int i = 0; i < 28; i++) begin
            do_frame(vecs[i].l, vecs[i].r, vecs[i].raw, vecs[i].bx, vecs[i].mv,
                     $sformatf("vec%0d", i));
        end

        // Press between ticks, released before the next tick: no movement.
        @(negedge clk);
        bus.btn_r = 1'b1;
        repeat (5) @(negedge clk);
        bus.btn_r = 1'b0;
        repeat (3) @(negedge clk);
        do_frame(0, 0, 2, 300, 0, "between_ticks");

        // Reach FAST at 400, then reset asynchronously between clock edges.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) do_frame(0, 1, 2, 290 + 2 * i, 1, "rst_slow");
        for (int i = 0; i < 16; i++) do_frame(0, 1, 2, 310 + 6 * i, 1, "rst_fast");
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("async_rst_board_x", {1'b0, bus.board_x}, 11'd288);
        chk("async_rst_moving", {10'd0, bus.moving}, 11'd0);
        @(negedge clk);
        reset = 1'b0;
        do_frame(0, 1, 2, 290, 1, "after_rst_slow");
        do_frame(0, 0, 2, 290, 0, "after_rst_idle");

        // Left wall: run down to 4, stop, then clamp at 0.
        for (int i = 0; i < 8; i++) do_frame(1, 0, 2, 288 - 2 * i, 1, "left_slow");
        for (int i = 0; i < 45; i++) do_frame(1, 0, 2, 268 - 6 * i, 1, "left_fast");
        do_frame(0, 0, 2, 4, 0, "left_stop4");
        do_frame(1, 0, 2, 2, 1, "left_wall_a");
        do_frame(1, 0, 2, 0, 1, "left_wall_b");
        do_frame(1, 0, 2, 0, 1, "left_wall_c");
        do_frame(1, 0, 2, 0, 1, "left_wall_d");
        do_frame(0, 0, 2, 0, 0, "left_release");

        // Right wall: run up to 574, stop, then clamp at 576, holding into FAST.
        for (int i = 0; i < 8; i++) do_frame(0, 1, 2, 2 + 2 * i, 1, "right_slow");
        for (int i = 0; i < 93; i++) do_frame(0, 1, 2, 22 + 6 * i, 1, "right_fast");
        do_frame(0, 0, 2, 574, 0, "right_stop574");
        for (int i = 0; i < 10; i++) do_frame(0, 1, 2, 576, 1, "right_wall");
        do_frame(1, 1, 2, 576, 0, "right_both_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
